// File: rtl/hgame_pkg.sv
// rtl/hgame_pkg.sv - shared state encoding and result codes for the hunch game referee
package hgame_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ONE_A = 3'd1,
      ONE_B = 3'd2,
      ONE_C = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Winner masks are ordered {A,B,C}
   localparam logic [2:0] W_NONE = 3'b000;
   localparam logic [2:0] W_A    = 3'b100;
   localparam logic [2:0] W_B    = 3'b010;
   localparam logic [2:0] W_C    = 3'b001;
   localparam logic [2:0] W_AB   = 3'b110;
   localparam logic [2:0] W_AC   = 3'b101;
   localparam logic [2:0] W_BC   = 3'b011;
   localparam logic [2:0] W_DRAW = 3'b111;

   function automatic logic [1:0] count3(input logic [2:0] m);
      return {1'b0, m[2]} + {1'b0, m[1]} + {1'b0, m[0]};
   endfunction

endpackage

// File: rtl/hgame_judge.sv
// rtl/hgame_judge.sv - combinational next-state and winner decision for one round
module hgame_judge
   import hgame_pkg::*;
(
   input  state_t     state,
   input  logic [2:0] new_mask,
   output state_t     state_next,
   output logic [2:0] winner_next
);

   logic [2:0] first_mask;

   always_comb begin
      state_next  = state;
      winner_next = W_NONE;
      first_mask  = W_NONE;
      case (state)
         IDLE: begin
            case (count3(new_mask))
               2'd1: begin
                  case (new_mask)
                     W_A:     state_next = ONE_A;
                     W_B:     state_next = ONE_B;
                     default: state_next = ONE_C;
                  endcase
               end
               2'd2: begin
                  winner_next = ~new_mask;
                  state_next  = DONE;
               end
               2'd3: begin
                  winner_next = W_DRAW;
                  state_next  = DONE;
               end
               default: state_next = IDLE;
            endcase
         end
         ONE_A, ONE_B, ONE_C: begin
            first_mask = (state == ONE_A) ? W_A : (state == ONE_B) ? W_B : W_C;
            // A lone second presser shares the win; a collision leaves only the first
            case (count3(new_mask))
               2'd1: begin
                  winner_next = first_mask | new_mask;
                  state_next  = DONE;
               end
               2'd2: begin
                  winner_next = first_mask;
                  state_next  = DONE;
               end
               default: state_next = state;
            endcase
         end
         DONE:    state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - three-player hunch game referee; latches the winner mask until reset
module main_fsm
   import hgame_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   output logic [2:0] WINNER_DISP
);

   state_t     state;
   state_t     state_next;
   logic [2:0] pressed;
   logic [2:0] new_mask;
   logic [2:0] winner_next;

   // Players who already pressed are masked out, held or re-pressed
   assign new_mask = {A, B, C} & ~pressed;

   hgame_judge u_judge (
      .state       (state),
      .new_mask    (new_mask),
      .state_next  (state_next),
      .winner_next (winner_next)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         pressed     <= W_NONE;
         WINNER_DISP <= W_NONE;
      end else if (state != DONE) begin
         state       <= state_next;
         pressed     <= pressed | {A, B, C};
         WINNER_DISP <= winner_next;
      end
   end

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - directed self-checking bench for main_fsm
module tb_main_fsm;

   logic       CLK;
   logic       RST;
   logic       A;
   logic       B;
   logic       C;
   logic [2:0] WINNER_DISP;

   int tests_run    = 0;
   int tests_failed = 0;

   main_fsm dut (
      .CLK         (CLK),
      .RST         (RST),
      .A           (A),
      .B           (B),
      .C           (C),
      .WINNER_DISP (WINNER_DISP)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic test_reset();
      RST = 1'b1;
      {A, B, C} = 3'b111;
      repeat (3) @(posedge CLK);
      #1;
      tests_run++;
      if (WINNER_DISP !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_hold: got %b expected 000", WINNER_DISP);
      end
      RST = 1'b0;
      {A, B, C} = 3'b000;
   endtask

   // Pulses RST mid-cycle, checks the async clear, then plays up to four steps
   task automatic test_round(input string name, input int n,
                             input logic [2:0] v0, input logic [2:0] v1,
                             input logic [2:0] v2, input logic [2:0] v3,
                             input logic [2:0] exp);
      logic [2:0] seq [4];
      logic [2:0] want;
      seq[0] = v0; seq[1] = v1; seq[2] = v2; seq[3] = v3;
      RST = 1'b1;
      #1;
      tests_run++;
      if (WINNER_DISP !== 3'b000) begin
         tests_failed++;
         $display("FAIL %s_async_clear: got %b expected 000", name, WINNER_DISP);
      end
      RST = 1'b0;
      for (int i = 0; i < n; i++) begin
         {A, B, C} = seq[i];
         @(posedge CLK);
         #1;
         want = (i == n - 1) ? exp : 3'b000;
         tests_run++;
         if (WINNER_DISP !== want) begin
            tests_failed++;
            $display("FAIL %s_step%0d: inputs %b got %b expected %b", name, i, seq[i], WINNER_DISP, want);
         end
      end
   endtask

   task automatic test_done_hold();
      test_round("hold_setup", 2, 3'b100, 3'b111, 3'b000, 3'b000, 3'b100);
      for (int i = 0; i < 4; i++) begin
         {A, B, C} = 3'($urandom_range(0, 7));
         @(posedge CLK);
         #1;
         tests_run++;
         if (WINNER_DISP !== 3'b100) begin
            tests_failed++;
            $display("FAIL done_hold%0d: got %b expected 100", i, WINNER_DISP);
         end
      end
   endtask

   task automatic test_async_reset_one_b();
      test_round("one_b_setup", 1, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000);
      {A, B, C} = 3'b000;
      #2 RST = 1'b1;
      #1 RST = 1'b0;
      tests_run++;
      if (WINNER_DISP !== 3'b000) begin
         tests_failed++;
         $display("FAIL one_b_reset: got %b expected 000", WINNER_DISP);
      end
      // From IDLE, A alone waits; from a stale ONE_B it would give 110
      {A, B, C} = 3'b100;
      @(posedge CLK);
      #1;
      tests_run++;
      if (WINNER_DISP !== 3'b000) begin
         tests_failed++;
         $display("FAIL one_b_after_a: got %b expected 000", WINNER_DISP);
      end
      {A, B, C} = 3'b001;
      @(posedge CLK);
      #1;
      tests_run++;
      if (WINNER_DISP !== 3'b101) begin
         tests_failed++;
         $display("FAIL one_b_after_c: got %b expected 101", WINNER_DISP);
      end
   endtask

   initial begin
      RST = 1'b1;
      {A, B, C} = 3'b000;
      test_reset();
      test_round("r1",  2, 3'b000, 3'b011, 3'b000, 3'b000, 3'b100);
      test_round("r2a", 1, 3'b101, 3'b000, 3'b000, 3'b000, 3'b010);
      test_round("r2b", 1, 3'b110, 3'b000, 3'b000, 3'b000, 3'b001);
      test_round("r3",  2, 3'b100, 3'b110, 3'b000, 3'b000, 3'b110);
      test_round("r4",  3, 3'b000, 3'b100, 3'b101, 3'b000, 3'b101);
      test_round("r5",  3, 3'b000, 3'b010, 3'b011, 3'b000, 3'b011);
      test_round("r6",  4, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111);
      test_round("r7",  2, 3'b100, 3'b111, 3'b000, 3'b000, 3'b100);
      test_round("r8",  1, 3'b101, 3'b000, 3'b000, 3'b000, 3'b010);
      test_round("c_first_collide", 2, 3'b001, 3'b110, 3'b000, 3'b000, 3'b001);
      test_round("c_then_a", 3, 3'b001, 3'b001, 3'b100, 3'b000, 3'b101);
      test_round("b_then_c_held", 3, 3'b010, 3'b010, 3'b011, 3'b000, 3'b011);
      test_done_hold();
      test_async_reset_one_b();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
